// File: rtl/demux1_4_buf_if.sv
// Producer/consumer bundle for the buffered 1-to-4 demultiplexer.
// The slave side is the demux; the master side is the producer plus the four consumers.
interface demux1_4_buf_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_select;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data_0;
    logic [WIDTH-1:0] out_data_1;
    logic [WIDTH-1:0] out_data_2;
    logic [WIDTH-1:0] out_data_3;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;

    modport master (
        output in_data, in_select, in_valid, out_ready,
        input  in_ready, out_data_0, out_data_1, out_data_2, out_data_3, out_valid
    );

    modport slave (
        input  in_data, in_select, in_valid, out_ready,
        output in_ready, out_data_0, out_data_1, out_data_2, out_data_3, out_valid
    );
endinterface

// File: rtl/demux1_4_buf.sv
// Buffered 1-to-4 demux: one word per cycle steered into four independent 2-entry FIFOs.
// in_ready depends only on in_select and registered occupancy, never on out_ready.
module demux1_4_buf #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    demux1_4_buf_if.slave bus
);
    logic [WIDTH-1:0] head [4];
    logic [WIDTH-1:0] tail [4];
    logic [1:0]       count [4];
    logic [3:0]       push;
    logic [3:0]       pop;
    logic             ready;

    // A full channel refuses a push even when it pops in the same cycle.
    assign ready       = (count[bus.in_select] != 2'd2);
    assign bus.in_ready = ready;

    always_comb begin
        push = '0;
        pop  = '0;
        for (int n = 0; n < 4; n++) begin
            push[n] = bus.in_valid & ready & (bus.in_select == 2'(n));
            pop[n]  = (count[n] != 2'd0) & bus.out_ready[n];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 4; n++) begin
                head[n]  <= '0;
                tail[n]  <= '0;
                count[n] <= 2'd0;
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                case ({push[n], pop[n]})
                    2'b10: begin
                        if (count[n] == 2'd0) begin
                            head[n] <= bus.in_data;
                        end else begin
                            tail[n] <= bus.in_data;
                        end
                        count[n] <= count[n] + 2'd1;
                    end
                    2'b01: begin
                        if (count[n] == 2'd2) begin
                            head[n] <= tail[n];
                        end
                        count[n] <= count[n] - 2'd1;
                    end
                    // Push with pop only happens at count 1: the new word becomes the head.
                    2'b11: begin
                        head[n] <= bus.in_data;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_comb begin
        bus.out_valid = '0;
        for (int n = 0; n < 4; n++) begin
            bus.out_valid[n] = (count[n] != 2'd0);
        end
    end

    assign bus.out_data_0 = head[0];
    assign bus.out_data_1 = head[1];
    assign bus.out_data_2 = head[2];
    assign bus.out_data_3 = head[3];
endmodule

// File: tb/tb_demux1_4_buf.sv
// Directed vector table plus reset and random-stress sequences for demux1_4_buf.
module tb_demux1_4_buf;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    demux1_4_buf_if #(.WIDTH(32)) bus ();

    demux1_4_buf #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] od [4];
    assign od[0] = bus.out_data_0;
    assign od[1] = bus.out_data_1;
    assign od[2] = bus.out_data_2;
    assign od[3] = bus.out_data_3;

    typedef struct {
        logic        vld;
        logic [1:0]  sel;
        logic [31:0] data;
        logic [3:0]  ordy;
        logic        exp_rdy;
        logic [3:0]  exp_ov;
        logic [31:0] exp_d [4];
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic vld, input logic [1:0] sel, input logic [31:0] data,
                       input logic [3:0] ordy, input logic exp_rdy, input logic [3:0] exp_ov,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] d3);
        vec_t v;
        v.vld = vld; v.sel = sel; v.data = data; v.ordy = ordy;
        v.exp_rdy = exp_rdy; v.exp_ov = exp_ov;
        v.exp_d[0] = d0; v.exp_d[1] = d1; v.exp_d[2] = d2; v.exp_d[3] = d3;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic [1:0] sel, input logic [31:0] data,
                         input logic [3:0] ordy);
        bus.in_valid  = vld;
        bus.in_select = sel;
        bus.in_data   = data;
        bus.out_ready = ordy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] q [4][$];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_select = 2'd0; bus.in_data = '0; bus.out_ready = 4'h0;
        tick(); tick();
        rst = 1'b0;

        // Expectations describe state seen before the edge that applies the inputs.
        add(0, 0, 0,            4'hF, 1, 4'b0000, 0, 0, 0, 0);
        add(0, 3, 0,            4'hF, 1, 4'b0000, 0, 0, 0, 0);
        add(1, 0, 32'hA0000000, 4'hF, 1, 4'b0000, 0, 0, 0, 0);
        add(1, 1, 32'hA0000001, 4'hF, 1, 4'b0001, 32'hA0000000, 0, 0, 0);
        add(1, 2, 32'hA0000002, 4'hF, 1, 4'b0010, 0, 32'hA0000001, 0, 0);
        add(1, 3, 32'hA0000003, 4'hF, 1, 4'b0100, 0, 0, 32'hA0000002, 0);
        add(0, 0, 0,            4'hF, 1, 4'b1000, 0, 0, 0, 32'hA0000003);
        add(0, 0, 0,            4'hF, 1, 4'b0000, 0, 0, 0, 0);
        add(1, 1, 32'h100,      4'hD, 1, 4'b0000, 0, 0, 0, 0);
        add(1, 1, 32'h101,      4'hD, 1, 4'b0010, 0, 32'h100, 0, 0);
        add(1, 1, 32'h102,      4'hD, 0, 4'b0010, 0, 32'h100, 0, 0);
        add(1, 1, 32'h102,      4'hF, 0, 4'b0010, 0, 32'h100, 0, 0);
        add(1, 1, 32'h102,      4'hF, 1, 4'b0010, 0, 32'h101, 0, 0);
        add(0, 1, 0,            4'hF, 1, 4'b0010, 0, 32'h102, 0, 0);
        add(0, 1, 0,            4'hF, 1, 4'b0000, 0, 0, 0, 0);
        add(1, 3, 32'h300,      4'h7, 1, 4'b0000, 0, 0, 0, 0);
        add(1, 3, 32'h301,      4'hF, 1, 4'b1000, 0, 0, 0, 32'h300);
        add(0, 3, 0,            4'h7, 1, 4'b1000, 0, 0, 0, 32'h301);
        add(1, 3, 32'h302,      4'h7, 1, 4'b1000, 0, 0, 0, 32'h301);
        add(1, 3, 32'h303,      4'hF, 0, 4'b1000, 0, 0, 0, 32'h301);
        add(0, 3, 0,            4'h7, 1, 4'b1000, 0, 0, 0, 32'h302);
        add(0, 3, 0,            4'hF, 1, 4'b1000, 0, 0, 0, 32'h302);
        add(0, 3, 0,            4'hF, 1, 4'b0000, 0, 0, 0, 0);
        add(1, 0, 32'h400,      4'hE, 1, 4'b0000, 0, 0, 0, 0);
        add(1, 0, 32'h401,      4'hE, 1, 4'b0001, 32'h400, 0, 0, 0);
        add(1, 0, 32'h402,      4'hE, 0, 4'b0001, 32'h400, 0, 0, 0);
        add(1, 2, 32'h200,      4'hE, 1, 4'b0001, 32'h400, 0, 0, 0);
        add(0, 0, 0,            4'hE, 0, 4'b0101, 32'h400, 0, 32'h200, 0);
        add(0, 2, 0,            4'hE, 1, 4'b0001, 32'h400, 0, 0, 0);
        add(0, 0, 0,            4'hF, 0, 4'b0001, 32'h400, 0, 0, 0);
        add(0, 0, 0,            4'hF, 1, 4'b0001, 32'h401, 0, 0, 0);
        add(0, 0, 0,            4'hF, 1, 4'b0000, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].vld, vecs[i].sel, vecs[i].data, vecs[i].ordy);
            chk($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'(vecs[i].exp_rdy));
            chk($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_ov));
            for (int c = 0; c < 4; c++) begin
                if (vecs[i].exp_ov[c]) begin
                    chk($sformatf("vec%0d out_data_%0d", i, c), od[c], vecs[i].exp_d[c]);
                end
            end
            tick();
        end

        // Reset mid-traffic with channel 2 holding two words.
        drive(1, 2, 32'hDEAD0001, 4'h0); tick();
        drive(1, 2, 32'hDEAD0002, 4'h0); tick();
        chk("pre-reset ch2 full", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        drive(1, 2, 32'hDEAD0003, 4'hF); tick();
        drive(1, 1, 32'hDEAD0004, 4'hF); tick();
        rst = 1'b0;
        drive(0, 0, 0, 4'h0);
        chk("post-reset out_valid", 32'(bus.out_valid), 32'd0);
        for (int s = 0; s < 4; s++) begin
            drive(0, 2'(s), 0, 4'h0);
            chk($sformatf("post-reset in_ready sel%0d", s), 32'(bus.in_ready), 32'd1);
        end
        drive(1, 2, 32'h11111111, 4'h0); tick();
        drive(0, 2, 0, 4'hF);
        chk("post-reset first out_valid", 32'(bus.out_valid), 32'b0100);
        chk("post-reset first data", od[2], 32'h11111111);
        tick();
        drive(0, 2, 0, 4'hF);
        chk("post-reset alone", 32'(bus.out_valid), 32'd0);
        tick();

        // Random stress against a per-channel queue model.
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic        vld;
            logic [1:0]  sel;
            logic [31:0] data;
            logic [3:0]  ordy;
            logic        exp_rdy;
            logic [3:0]  exp_ov;
            vld  = 1'($urandom_range(0, 1));
            sel  = 2'($urandom_range(0, 3));
            data = $urandom;
            ordy = 4'($urandom_range(0, 15));
            drive(vld, sel, data, ordy);
            exp_rdy = (q[sel].size() != 2);
            exp_ov  = '0;
            for (int c = 0; c < 4; c++) exp_ov[c] = (q[c].size() != 0);
            chk("stress in_ready", 32'(bus.in_ready), 32'(exp_rdy));
            chk("stress out_valid", 32'(bus.out_valid), 32'(exp_ov));
            for (int c = 0; c < 4; c++) begin
                if (exp_ov[c]) chk($sformatf("stress head ch%0d", c), od[c], q[c][0]);
            end
            for (int c = 0; c < 4; c++) begin
                if (exp_ov[c] && ordy[c]) void'(q[c].pop_front());
            end
            if (vld && exp_rdy) q[sel].push_back(data);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
